// File: rtl/byte_word_pkg.sv
// Shared types and sizes for the byte-to-word assembler slice.
package byte_word_pkg;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } state_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 16;

  // Order the two bytes of a word according to the configured byte order.
  function automatic logic [WORD_W-1:0] join_bytes(
    input logic              msb_first,
    input logic [BYTE_W-1:0] first_byte,
    input logic [BYTE_W-1:0] second_byte
  );
    if (msb_first) begin
      return {first_byte, second_byte};
    end else begin
      return {second_byte, first_byte};
    end
  endfunction

endpackage

// File: rtl/byte_word_assembler_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty come from an occupancy count
// one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_INC  = AW'(1'b1);
  localparam logic [AW:0]   CNT_INC  = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == CNT_FULL);
  assign empty   = (count_r == {(AW + 1){1'b0}});
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  // Force zero on the output while empty so stale storage never leaks out.
  assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array; needs no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr_s && rst) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_INC;
        2'b01:   count_r <= count_r - CNT_INC;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/byte_word_assembler.sv
// Packs a byte stream into 16-bit words, with realignment on in_align and an
// output FIFO that back-pressures the byte stream.
module byte_word_assembler
  import byte_word_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_align,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] word_cnt,
  output logic              align_err
);

  state_t            state_r;
  logic [BYTE_W-1:0] hold_r;
  logic [WORD_W-1:0] word_cnt_r;
  logic              align_err_r;
  logic              accept_s;
  logic              push_s;
  logic [WORD_W-1:0] push_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // Only a second byte can need FIFO space, so the first byte is never stalled.
  assign in_ready    = (state_r == FIRST) || !fifo_full_s;
  assign accept_s    = in_valid && in_ready;
  assign push_s      = accept_s && (state_r == SECOND) && !in_align;
  assign push_data_s = join_bytes(MSB_FIRST, hold_r, in_data);
  assign out_valid   = !fifo_empty_s;
  assign word_cnt    = word_cnt_r;
  assign align_err   = align_err_r;

  // Two-state byte pairing FSM with its hold register and status counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= FIRST;
      hold_r      <= 8'h00;
      word_cnt_r  <= 16'h0000;
      align_err_r <= 1'b0;
    end else if (accept_s) begin
      case (state_r)
        FIRST: begin
          hold_r  <= in_data;
          state_r <= SECOND;
        end
        SECOND: begin
          if (in_align) begin
            hold_r      <= in_data;
            align_err_r <= 1'b1;
          end else begin
            word_cnt_r <= word_cnt_r + 16'd1;
            state_r    <= FIRST;
          end
        end
        default: state_r <= FIRST;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data (push_data_s),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

endmodule

// File: tb/tb_byte_word_assembler.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share one byte stream.
module tb_byte_word_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_align = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, align_err0, align_err1;
  logic [15:0] out_data0, out_data1, word_cnt0, word_cnt1;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        m_state;
  logic [7:0]  m_hold;
  logic [15:0] m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  byte_word_assembler #(.DEPTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_align(in_align),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .word_cnt(word_cnt0), .align_err(align_err0));

  byte_word_assembler #(.DEPTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_align(in_align),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .word_cnt(word_cnt1), .align_err(align_err1));

  task automatic model_clear();
    m_state = 1'b0;
    m_hold  = 8'h00;
    m_cnt   = 16'h0000;
    m_err   = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // One clock: scoreboard pops at the falling edge, then advance past the rising edge.
  task automatic tick(output logic acc);
    logic [15:0] e;
    @(negedge clk);
    acc = rst && in_valid && in_ready0;
    if (rst && out_ready && out_valid0) begin
      chk_cnt++;
      if (q0.size() == 0) $display("FAIL sb_msb: got %h, required no word", out_data0);
      else begin
        e = q0.pop_front();
        if (out_data0 !== e) $display("FAIL sb_msb: got %h, required %h", out_data0, e);
        else pass_cnt++;
      end
    end
    if (rst && out_ready && out_valid1) begin
      chk_cnt++;
      if (q1.size() == 0) $display("FAIL sb_lsb: got %h, required no word", out_data1);
      else begin
        e = q1.pop_front();
        if (out_data1 !== e) $display("FAIL sb_lsb: got %h, required %h", out_data1, e);
        else pass_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    logic a;
    tick(a);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a);
    logic acc;
    acc = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    in_align = a;
    for (int i = 0; i < 50 && !acc; i++) tick(acc);
    in_valid = 1'b0;
    in_align = 1'b0;
    chk_cnt++;
    if (!acc) $display("FAIL accept_timeout: byte %h got no accept, required accept", b);
    else begin
      pass_cnt++;
      if (!m_state) begin
        m_hold = b; m_state = 1'b1;
      end else if (a) begin
        m_hold = b; m_err = 1'b1;
      end else begin
        q0.push_back({m_hold, b});
        q1.push_back({b, m_hold});
        m_cnt = m_cnt + 16'd1;
        m_state = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; in_align = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    model_clear();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (out_valid0 || out_valid1); i++) step();
    chk_cnt++;
    if (out_valid0 !== 1'b0 || q0.size() != 0 || q1.size() != 0)
      $display("FAIL drain: got valid=%b pending=%0d, required valid=0 pending=0", out_valid0, q0.size() + q1.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    step(); step();
    chk_cnt++;
    if (out_valid0 !== 1'b0 || out_data0 !== 16'h0000) $display("FAIL rst_out: got v=%b d=%h, required v=0 d=0000", out_valid0, out_data0);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready0 !== 1'b1 || word_cnt0 !== 16'h0000 || align_err0 !== 1'b0)
      $display("FAIL rst_status: got rdy=%b cnt=%h err=%b, required 1 0000 0", in_ready0, word_cnt0, align_err0);
    else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    model_clear();
    step();
    chk_cnt++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || out_data0 !== 16'h0000)
      $display("FAIL post_rst: got rdy=%b v=%b d=%h, required 1 0 0000", in_ready0, out_valid0, out_data0);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h35, 1'b0);
    send_byte(8'h24, 1'b0);
    chk_cnt++;
    if (out_valid0 !== 1'b1 || out_data0 !== 16'h3524) $display("FAIL basic_word: got v=%b d=%h, required v=1 d=3524", out_valid0, out_data0);
    else pass_cnt++;
    chk_cnt++;
    if (word_cnt0 !== 16'd1) $display("FAIL basic_cnt: got %0d, required 1", word_cnt0);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_byte_order();
    do_reset();
    send_byte(8'h81, 1'b0);
    send_byte(8'h5E, 1'b0);
    chk_cnt++;
    if (out_data1 !== 16'h5E81 || out_data0 !== 16'h815E) $display("FAIL byte_order: got lsb=%h msb=%h, required 5e81 815e", out_data1, out_data0);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b0);
    in_data = 8'h09; in_valid = 1'b1;
    step(); step(); step();
    chk_cnt++;
    if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) $display("FAIL bp_stall: got in_ready=%b%b, required 00", in_ready0, in_ready1);
    else pass_cnt++;
    chk_cnt++;
    if (word_cnt0 !== 16'd4) $display("FAIL bp_cnt_full: got %0d, required 4", word_cnt0);
    else pass_cnt++;
    out_ready = 1'b1;
    send_byte(8'h09, 1'b0);
    drain();
    chk_cnt++;
    if (word_cnt0 !== 16'd5 || align_err0 !== 1'b0) $display("FAIL bp_cnt: got cnt=%0d err=%b, required 5 0", word_cnt0, align_err0);
    else pass_cnt++;
  endtask

  task automatic test_realign();
    do_reset();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h56, 1'b1);
    send_byte(8'h63, 1'b0);
    chk_cnt++;
    if (out_data0 !== 16'h5663 || align_err0 !== 1'b1 || word_cnt0 !== 16'd1)
      $display("FAIL realign: got d=%h err=%b cnt=%0d, required 5663 1 1", out_data0, align_err0, word_cnt0);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h7B, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_clear();
    chk_cnt++;
    if (out_valid0 !== 1'b0 || word_cnt0 !== 16'd0) $display("FAIL mid_rst: got v=%b cnt=%0d, required 0 0", out_valid0, word_cnt0);
    else pass_cnt++;
    send_byte(8'h99, 1'b0);
    send_byte(8'h8D, 1'b0);
    chk_cnt++;
    if (out_data0 !== 16'h998D || word_cnt0 !== 16'd1 || align_err0 !== 1'b0)
      $display("FAIL mid_rst_word: got d=%h cnt=%0d err=%b, required 998d 1 0", out_data0, word_cnt0, align_err0);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
    end
    drain();
    chk_cnt++;
    if (word_cnt0 !== m_cnt || align_err0 !== m_err || word_cnt1 !== m_cnt)
      $display("FAIL b2b_status: got cnt=%0d err=%b, required %0d %b", word_cnt0, align_err0, m_cnt, m_err);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut0.word_cnt_r = 16'hFFFF;
    #1;
    release dut0.word_cnt_r;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk_cnt++;
    if (word_cnt0 !== 16'h0000 || out_data0 !== 16'h1234 || out_valid0 !== 1'b1)
      $display("FAIL wrap: got cnt=%h d=%h v=%b, required 0000 1234 1", word_cnt0, out_data0, out_valid0);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_byte_order();
    test_backpressure();
    test_realign();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
